// File: rtl/uart_word_loader_if.sv
// rtl/uart_word_loader_if.sv - Word-write and byte-observation bundle of the UART word loader
interface uart_word_loader_if #(
   parameter int ADDR_W = 8
);
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [31:0]       wdata;
   logic [7:0]        rx_data;
   logic              rx_byte_valid;
   logic [32:0]       rx_check;
   logic              frame_err;

   modport master (
      output we, waddr, wdata, rx_data, rx_byte_valid, rx_check, frame_err
   );

   modport slave (
      input we, waddr, wdata, rx_data, rx_byte_valid, rx_check, frame_err
   );
endinterface

// File: rtl/uart_word_loader.sv
// rtl/uart_word_loader.sv - 8N1 UART receiver packing little-endian bytes into 32-bit memory writes
// Macro UART_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module uart_word_loader #(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_W       = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               rx,
   uart_word_loader_if.master bus
);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t            state_q, state_d;
   logic              rx_meta_q, rx_sync_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [31:0]       word_q, word_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [7:0]        rx_data_q, rx_data_d;
   logic              valid_q, valid_d;
   logic [32:0]       check_q, check_d;
   logic              ferr_q, ferr_d;
   logic              accept;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CNT_W'(1);
      bit_d      = bit_q;
      shift_d    = shift_q;
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      addr_d     = addr_q;
      we_d       = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      rx_data_d  = rx_data_q;
      valid_d    = 1'b0;
      check_d    = check_q;
      ferr_d     = ferr_q;
      accept     = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx_sync_q) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               bit_d   = 3'd0;
               state_d = rx_sync_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               shift_d = {rx_sync_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_PARITY_EN
         S_PARITY: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               // Even parity: data bits plus parity bit must hold an even number of ones
               if (^shift_q ^ rx_sync_q) begin
                  ferr_d  = 1'b1;
                  state_d = S_WAIT_HIGH;
               end else begin
                  state_d = S_STOP;
               end
            end
         end
`endif
         S_STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               if (rx_sync_q) begin
                  accept  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_WAIT_HIGH;
               end
            end
         end
         S_WAIT_HIGH: begin
            cnt_d = '0;
            if (rx_sync_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Word address advances at the accept edge; waddr captures the pre-increment value
      if (accept) begin
         rx_data_d  = shift_q;
         valid_d    = 1'b1;
         word_d[{byte_idx_q, 3'b000} +: 8] = shift_q;
         byte_idx_d = byte_idx_q + 2'd1;
         if (byte_idx_q == 2'd3) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = {shift_q, word_q[23:0]};
            check_d = {1'b1, shift_q, word_q[23:0]};
            addr_d  = addr_q + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         cnt_q      <= '0;
         bit_q      <= 3'd0;
         shift_q    <= 8'd0;
         byte_idx_q <= 2'd0;
         word_q     <= 32'd0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= 32'd0;
         rx_data_q  <= 8'd0;
         valid_q    <= 1'b0;
         check_q    <= 33'd0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_meta_q  <= rx;
         rx_sync_q  <= rx_meta_q;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         byte_idx_q <= byte_idx_d;
         word_q     <= word_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         rx_data_q  <= rx_data_d;
         valid_q    <= valid_d;
         check_q    <= check_d;
         ferr_q     <= ferr_d;
      end
   end

   assign bus.we            = we_q;
   assign bus.waddr         = waddr_q;
   assign bus.wdata         = wdata_q;
   assign bus.rx_data       = rx_data_q;
   assign bus.rx_byte_valid = valid_q;
   assign bus.rx_check      = check_q;
   assign bus.frame_err     = ferr_q;
endmodule

// File: tb/tb_uart_word_loader.sv
// tb/tb_uart_word_loader.sv - Table, directed and random checks of uart_word_loader against a byte/word scoreboard
`timescale 1ns/1ps
module tb_uart_word_loader;
   localparam int CPB = 16;
   localparam int AW  = 2;
`ifdef UART_PARITY_EN
   localparam bit HAS_PARITY = 1'b1;
   localparam int FRAME_BITS = 11;
`else
   localparam bit HAS_PARITY = 1'b0;
   localparam int FRAME_BITS = 10;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic rx    = 1'b1;

   uart_word_loader_if #(.ADDR_W(AW)) bus ();
   uart_word_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .rx    (rx),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   logic [7:0]    obs_bytes[$];
   logic [AW-1:0] obs_addr[$];
   logic [31:0]   obs_word[$];
   logic [32:0]   obs_chk[$];
   time           last_valid_t = 0;
   time           frame_t = 0;
   logic          prev_valid = 1'b0;
   logic          prev_we = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         if (prev_valid) check("valid_one_cycle", bus.rx_byte_valid, 0);
         if (prev_we) check("we_one_cycle", bus.we, 0);
         if (bus.rx_byte_valid) begin
            obs_bytes.push_back(bus.rx_data);
            last_valid_t = $time;
         end
         if (bus.we) begin
            check("we_with_valid", bus.rx_byte_valid, 1);
            obs_addr.push_back(bus.waddr);
            obs_word.push_back(bus.wdata);
            obs_chk.push_back(bus.rx_check);
         end
      end
      prev_valid = bus.rx_byte_valid;
      prev_we    = bus.we;
   end

   logic [7:0]    exp_bytes[$];
   logic [AW-1:0] exp_addr[$];
   logic [31:0]   exp_word[$];
   int            m_idx, m_addr;
   logic [31:0]   m_word, m_last;
   logic          m_ferr, m_seen;

   function automatic void model_reset();
      m_idx = 0; m_addr = 0; m_word = 0; m_last = 0; m_ferr = 0; m_seen = 0;
      exp_bytes.delete(); exp_addr.delete(); exp_word.delete();
      obs_bytes.delete(); obs_addr.delete(); obs_word.delete(); obs_chk.delete();
   endfunction

   function automatic void model_frame(input logic [7:0] d, input logic ok);
      if (!ok) begin
         m_ferr = 1'b1;
         return;
      end
      exp_bytes.push_back(d);
      m_word = m_word | (32'(d) << (8 * m_idx));
      m_idx++;
      if (m_idx == 4) begin
         exp_addr.push_back(AW'(m_addr));
         exp_word.push_back(m_word);
         m_last = m_word;
         m_seen = 1'b1;
         m_addr = (m_addr + 1) % (1 << AW);
         m_idx  = 0;
         m_word = 0;
      end
   endfunction

   task automatic drive_bit(input logic b);
      @(negedge clk);
      rx = b;
      repeat (CPB - 1) @(negedge clk);
   endtask

   task automatic idle(input int nbits);
      rx = 1'b1;
      repeat (nbits * CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bad);
      @(negedge clk);
      rx = 1'b0;
      frame_t = $time;
      repeat (CPB - 1) @(negedge clk);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (HAS_PARITY) drive_bit(^d ^ par_bad);
      drive_bit(stop_bit);
      rx = 1'b1;
      model_frame(d, stop_bit && !(HAS_PARITY && par_bad));
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_we", bus.we, 0);
      check("rst_waddr", bus.waddr, 0);
      check("rst_wdata", bus.wdata, 0);
      check("rst_rx_data", bus.rx_data, 0);
      check("rst_valid", bus.rx_byte_valid, 0);
      check("rst_rx_check", bus.rx_check, 0);
      check("rst_frame_err", bus.frame_err, 0);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   task automatic compare_all(input string tag);
      logic [31:0] w;
      check({tag, ":bytes"}, obs_bytes.size(), exp_bytes.size());
      check({tag, ":words"}, obs_word.size(), exp_word.size());
      while (obs_bytes.size() > 0 && exp_bytes.size() > 0)
         check({tag, ":rx_data"}, obs_bytes.pop_front(), exp_bytes.pop_front());
      while (obs_word.size() > 0 && exp_word.size() > 0) begin
         w = exp_word.pop_front();
         check({tag, ":waddr"}, obs_addr.pop_front(), exp_addr.pop_front());
         check({tag, ":wdata"}, obs_word.pop_front(), w);
         check({tag, ":we_rx_check"}, obs_chk.pop_front(), {1'b1, w});
      end
      check({tag, ":rx_check"}, bus.rx_check, {m_seen, m_last});
      check({tag, ":frame_err"}, bus.frame_err, m_ferr);
      obs_bytes.delete(); obs_addr.delete(); obs_word.delete(); obs_chk.delete();
      exp_bytes.delete(); exp_addr.delete(); exp_word.delete();
   endtask

   typedef struct {
      logic [7:0] d;
      logic       stop;
      logic       exp_acc;
      logic       exp_ferr;
   } vec_t;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[13];
      int   lat, exp_lat;
      logic [7:0] rd;
      logic sb, pb;

      tbl[0]  = '{8'h55, 1'b1, 1'b1, 1'b0};
      tbl[1]  = '{8'h07, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{8'h00, 1'b1, 1'b1, 1'b0};
      tbl[3]  = '{8'h00, 1'b1, 1'b1, 1'b0};
      tbl[4]  = '{8'hA3, 1'b0, 1'b0, 1'b1};
      tbl[5]  = '{8'h11, 1'b1, 1'b1, 1'b1};
      tbl[6]  = '{8'h22, 1'b1, 1'b1, 1'b1};
      tbl[7]  = '{8'h33, 1'b1, 1'b1, 1'b1};
      tbl[8]  = '{8'h44, 1'b1, 1'b1, 1'b1};
      tbl[9]  = '{8'hFF, 1'b1, 1'b1, 1'b1};
      tbl[10] = '{8'h80, 1'b1, 1'b1, 1'b1};
      tbl[11] = '{8'h00, 1'b0, 1'b0, 1'b1};
      tbl[12] = '{8'h01, 1'b1, 1'b1, 1'b1};

      // Single byte: data, pulse latency from start edge, no word write
      do_reset();
      send_frame(8'h55, 1'b1, 1'b0);
      idle(3);
      lat     = int'((last_valid_t - frame_t) / 10);
      exp_lat = 3 + CPB * FRAME_BITS - CPB / 2;
      check("latency_window", (lat >= exp_lat - 2 && lat <= exp_lat + 2), 1);
      compare_all("byte55");

      // Back-to-back word
      do_reset();
      send_frame(8'h07, 1'b1, 1'b0);
      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'h00, 1'b1, 1'b0);
      idle(3);
      check("word7_rx_check", bus.rx_check, 33'h1_00000007);
      compare_all("word7");

      // Five words, address wraps mod 4
      do_reset();
      for (int w = 1; w <= 5; w++)
         for (int b = 0; b < 4; b++) send_frame(8'((w >> (8 * b)) & 8'hFF), 1'b1, 1'b0);
      idle(3);
      check("wrap_last_waddr", bus.waddr, 0);
      compare_all("wrap");

      // Short low glitch, then broken stop bit, then recovery into lane 0
      do_reset();
      @(negedge clk);
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      idle(2);
      compare_all("glitch");
      send_frame(8'hA3, 1'b0, 1'b0);
      idle(2);
      compare_all("break");
      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      send_frame(8'h33, 1'b1, 1'b0);
      send_frame(8'h44, 1'b1, 1'b0);
      idle(3);
      check("recover_lane0", bus.wdata[7:0], 8'h11);
      compare_all("recover");

      // Reset in the middle of bit 4 of the second byte of a word
      do_reset();
      send_frame(8'h9A, 1'b0, 1'b0);
      idle(1);
      send_frame(8'hBC, 1'b1, 1'b0);
      idle(2);
      compare_all("pre_reset");
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB - 1) @(negedge clk);
      rd = 8'hDE;
      for (int i = 0; i < 4; i++) drive_bit(rd[i]);
      @(negedge clk);
      rx = rd[4];
      repeat (CPB / 2) @(negedge clk);
      do_reset();
      idle(1);
      send_frame(8'h78, 1'b1, 1'b0);
      send_frame(8'h56, 1'b1, 1'b0);
      send_frame(8'h34, 1'b1, 1'b0);
      send_frame(8'h12, 1'b1, 1'b0);
      idle(3);
      check("post_reset_wdata", bus.wdata, 32'h12345678);
      compare_all("post_reset");

      // Table vectors
      do_reset();
      for (int i = 0; i < 13; i++) begin
         send_frame(tbl[i].d, tbl[i].stop, 1'b0);
         idle(2);
         check($sformatf("tbl%0d_accept", i), obs_bytes.size(), tbl[i].exp_acc);
         check($sformatf("tbl%0d_ferr", i), bus.frame_err, tbl[i].exp_ferr);
         compare_all($sformatf("tbl%0d", i));
      end

      // Random traffic with occasional bad stop / parity bits
      do_reset();
      for (int i = 0; i < 40; i++) begin
         rd = 8'($urandom);
         sb = ($urandom_range(0, 7) != 0);
         pb = HAS_PARITY && ($urandom_range(0, 7) == 0);
         send_frame(rd, sb, pb);
         if (!sb) idle(1);
         else idle($urandom_range(0, 1));
      end
      idle(3);
      compare_all("random");

`ifdef UART_PARITY_EN
      do_reset();
      send_frame(8'h03, 1'b1, 1'b1);
      idle(2);
      check("par_bad_ferr", bus.frame_err, 1);
      compare_all("par_bad");
      send_frame(8'h03, 1'b1, 1'b0);
      idle(2);
      check("par_good_rx_data", bus.rx_data, 8'h03);
      compare_all("par_good");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
